// File: rtl/c3lib_gf_clkmux_seq.sv
// c3lib_gf_clkmux_seq
// Switch sequencer for the glitch-free clock mux select. A request is accepted
// only in IDLE. The downstream domain is quiesced by handshake, the new select is
// driven, and the sequencer waits for both mux sync chains to settle. Quiesce is
// then released and the result is reported as a done pulse or a sticky error.
// Runs on the always-on reference clock.
module c3lib_gf_clkmux_seq #(
    parameter int   SETTLE_CYC  = 16,
    parameter int   TIMEOUT_CYC = 256,
    parameter logic SEL_RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_vld,
    input  logic i_req_sel,
    output logic o_req_rdy,
    output logic o_quiesce,
    input  logic i_quiesce_ack,
    output logic o_sel_clk,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);

    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             sel_q,     sel_d;
    logic             tgt_q,     tgt_d;
    logic             quiesce_q, quiesce_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    // Next-state logic: a request handshake in IDLE, then the quiesce/switch/settle/release walk
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        tgt_d     = tgt_q;
        quiesce_d = quiesce_q;
        done_d    = 1'b0;
        err_d     = err_q;
        accept    = i_req_vld && (state_q == ST_IDLE);
        cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (i_req_sel == sel_q) begin
                        // Already on the requested clock: report done without disturbing traffic
                        done_d = 1'b1;
                    end else begin
                        tgt_d     = i_req_sel;
                        quiesce_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_QUIESCE;
                    end
                end
            end
            ST_QUIESCE: begin
                if (i_quiesce_ack) begin
                    state_d = ST_SWITCH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d     = 1'b1;
                    quiesce_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SWITCH: begin
                sel_d   = tgt_q;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    quiesce_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!i_quiesce_ack) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                quiesce_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset aborts any switch in progress
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= SEL_RST_VAL;
            tgt_q     <= SEL_RST_VAL;
            quiesce_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            tgt_q     <= tgt_d;
            quiesce_q <= quiesce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_req_rdy = (state_q == ST_IDLE);
    assign o_quiesce = quiesce_q;
    assign o_sel_clk = sel_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_c3lib_gf_clkmux_seq.sv
// tb_c3lib_gf_clkmux_seq
// Directed bench for the clock-mux switch sequencer, SETTLE_CYC=16, TIMEOUT_CYC=8.
module tb_c3lib_gf_clkmux_seq;

    logic clk;
    logic rst_n;
    logic req_vld;
    logic req_sel;
    logic quiesce_ack;
    logic req_rdy;
    logic quiesce;
    logic sel_clk;
    logic busy;
    logic done;
    logic err;

    int checkCount   = 0;
    int failCount    = 0;
    int doneCount    = 0;
    int quiesceSeen  = 0;

    c3lib_gf_clkmux_seq #(
        .SETTLE_CYC (16),
        .TIMEOUT_CYC(8),
        .SEL_RST_VAL(1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_vld    (req_vld),
        .i_req_sel    (req_sel),
        .o_req_rdy    (req_rdy),
        .o_quiesce    (quiesce),
        .i_quiesce_ack(quiesce_ack),
        .o_sel_clk    (sel_clk),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    // Free-running reference clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses and note any quiesce assertion, sampled away from the active edge
    always @(negedge clk) begin
        if (done)    doneCount   <= doneCount + 1;
        if (quiesce) quiesceSeen <= quiesceSeen + 1;
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic sel, input logic ack);
        req_vld     = vld;
        req_sel     = sel;
        quiesce_ack = ack;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        int n;
        int doneBase;
        int qBase;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepClock();
        stepClock();

        // Reset state
        checkOutput("rst_sel",     sel_clk, 0);
        checkOutput("rst_busy",    busy,    0);
        checkOutput("rst_rdy",     req_rdy, 1);
        checkOutput("rst_quiesce", quiesce, 0);
        checkOutput("rst_err",     err,     0);
        checkOutput("rst_done",    done,    0);
        rst_n = 1'b1;
        stepClock();

        // Normal switch to clock B; ack rises a few cycles after quiesce
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sw_quiesce_up", quiesce, 1);
        checkOutput("sw_rdy_busy",   req_rdy, 0);
        checkOutput("sw_busy",       busy,    1);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("sw_sel_wait",   sel_clk, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepClock();
        checkOutput("sw_sel_switch", sel_clk, 0);
        stepClock();
        checkOutput("sw_sel_new",    sel_clk, 1);

        // Select must lead quiesce release by exactly the settle time; a busy request is dropped
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) applyStimulus(1'b1, 1'b0, 1'b1);
            stepClock();
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
            if (!quiesce) break;
        end
        checkOutput("sw_settle_len",  n,       16);
        checkOutput("sw_release_bsy", busy,    1);
        checkOutput("sw_no_early_dn", doneCount - doneBase, 0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("sw_done",      done,    1);
        checkOutput("sw_idle",      busy,    0);
        checkOutput("sw_sel_final", sel_clk, 1);
        checkOutput("sw_err",       err,     0);
        stepClock();
        checkOutput("sw_done_drop", done,    0);
        stepClock();
        checkOutput("sw_one_done",  doneCount - doneBase, 1);
        checkOutput("sw_sel_kept",  sel_clk, 1);

        // Request for the clock already selected completes without quiescing
        doneBase = doneCount;
        qBase    = quiesceSeen;
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("noop_done", done, 1);
        checkOutput("noop_busy", busy, 0);
        stepClock();
        checkOutput("noop_done_drop", done, 0);
        stepClock();
        checkOutput("noop_no_quiesce", quiesceSeen - qBase, 0);
        checkOutput("noop_one_done",   doneCount - doneBase, 1);

        // Ack never arrives: error after eight cycles in QUIESCE, select unchanged
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) stepClock();
        checkOutput("to_err_early",  err,  0);
        checkOutput("to_busy_early", busy, 1);
        stepClock();
        checkOutput("to_err",      err,     1);
        checkOutput("to_idle",     busy,    0);
        checkOutput("to_quiesce",  quiesce, 0);
        checkOutput("to_sel",      sel_clk, 1);
        stepClock();
        checkOutput("to_err_stick", err, 1);
        checkOutput("to_no_done",   doneCount - doneBase, 0);

        // Retry clears the error and completes normally
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rt_err_clr", err, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            stepClock();
            n++;
            if (!quiesce) break;
        end
        checkOutput("rt_release_at", n, 18);
        applyStimulus(1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            stepClock();
            n++;
            if (done) break;
        end
        checkOutput("rt_done_at", n, 1);
        checkOutput("rt_sel",     sel_clk, 0);
        checkOutput("rt_err",     err,     0);
        stepClock();
        checkOutput("rt_one_done", doneCount - doneBase, 1);

        // Reset in the middle of SETTLE aborts back to IDLE and the reset select
        applyStimulus(1'b1, 1'b1, 1'b1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepClock();
        stepClock();
        checkOutput("mr_sel_new", sel_clk, 1);
        stepClock();
        stepClock();
        rst_n = 1'b0;
        stepClock();
        checkOutput("mr_sel",     sel_clk, 0);
        checkOutput("mr_quiesce", quiesce, 0);
        checkOutput("mr_busy",    busy,    0);
        checkOutput("mr_rdy",     req_rdy, 1);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepClock();
        stepClock();
        checkOutput("mr_stay_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
